// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
// Shared types and defaults for the sequential shift-add multiplier.
//   mult_state_t  : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DEFAULT_WIDTH : default operand width in bits
// ---------------------------------------------------------------------------
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_multiplier_abs.sv
// ---------------------------------------------------------------------------
// mult_abs
// Combinational magnitude/sign split of one operand.
// Ports:
//   value_i     [WIDTH-1:0]  operand as presented on the input bus
//   is_signed_i              1 = treat value_i as two's complement
//   magnitude_o [WIDTH-1:0]  |value_i| as an unsigned WIDTH-bit number
//   sign_o                   1 when value_i is a negative signed operand
// The most negative value -2^(WIDTH-1) maps to 2^(WIDTH-1), which is exact
// because the magnitude is read as unsigned.
// ---------------------------------------------------------------------------
module mult_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             is_signed_i,
  output logic [WIDTH-1:0] magnitude_o,
  output logic             sign_o
);

  assign sign_o      = is_signed_i & value_i[WIDTH-1];
  assign magnitude_o = sign_o ? ((~value_i) + WIDTH'(1)) : value_i;

endmodule : mult_abs

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-add multiplier, one partial-product step per clock.
// Operands are converted to magnitudes at accept time; the product sign is
// re-applied on the last CALC edge.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set valid           in_ready  block can accept operands
//   a, b       multiplicand / multiplier   is_signed 1 = two's-complement
//   out_valid  result valid                out_ready consumer takes result
//   result     2*WIDTH-bit product         busy      high in CALC or DONE
// Build option:
//   SEQ_MULT_EARLY_TERM_EN - CALC also ends once the remaining multiplier
//   bits are all zero, so latency follows the highest set bit of |b|.
// ---------------------------------------------------------------------------
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t        state_q, state_d;
  logic [2*WIDTH-1:0] ma_q;       // shifted multiplicand magnitude
  logic [WIDTH-1:0]   mb_q;       // shifted multiplier magnitude
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mb_shift;
  logic               calc_last;

  mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value_i     (a),
    .is_signed_i (is_signed),
    .magnitude_o (mag_a),
    .sign_o      (sign_a)
  );

  mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value_i     (b),
    .is_signed_i (is_signed),
    .magnitude_o (mag_b),
    .sign_o      (sign_b)
  );

  // One shift-add step; cannot overflow since |a|*|b| < 2^(2*WIDTH).
  assign acc_next = acc_q + (mb_q[0] ? ma_q : '0);
  assign mb_shift = mb_q >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop on the edge that consumes the last nonzero multiplier bit.
  assign calc_last = (cnt_q == CW'(1)) || (mb_shift == '0);
`else
  assign calc_last = (cnt_q == CW'(1));
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (calc_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  assign result = result_q;

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ma_q  <= {{WIDTH{1'b0}}, mag_a};
            mb_q  <= mag_b;
            neg_q <= sign_a ^ sign_b;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc_q <= acc_next;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_shift;
          cnt_q <= cnt_q - CW'(1);
          if (calc_last) begin
            result_q <= neg_q ? -acc_next : acc_next;
          end
        end
        default: ;  // DONE: result held until consumed
      endcase
    end
  end

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed and random checks of seq_multiplier at WIDTH=8 and WIDTH=5.
// Expected products come from a signed-integer reference model and travel
// through a scoreboard queue from accept to result handshake.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, is_signed;
  logic [31:0] a_v, b_v;
  logic        sel5;

  logic        in_valid8, in_ready8, out_valid8, busy8;
  logic [15:0] result8;
  logic        in_valid5, in_ready5, out_valid5, busy5;
  logic [9:0]  result5;

  logic        cur_in_ready, cur_out_valid, cur_busy;
  logic [63:0] cur_result;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  assign in_valid8     = in_valid & ~sel5;
  assign in_valid5     = in_valid & sel5;
  assign cur_in_ready  = sel5 ? in_ready5  : in_ready8;
  assign cur_out_valid = sel5 ? out_valid5 : out_valid8;
  assign cur_busy      = sel5 ? busy5      : busy8;
  assign cur_result    = sel5 ? {54'b0, result5} : {48'b0, result8};

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a_v[7:0]),
    .b         (b_v[7:0]),
    .is_signed (is_signed),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .result    (result8),
    .busy      (busy8)
  );

  seq_multiplier #(.WIDTH(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .a         (a_v[4:0]),
    .b         (b_v[4:0]),
    .is_signed (is_signed),
    .out_valid (out_valid5),
    .out_ready (out_ready),
    .result    (result5),
    .busy      (busy5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: sign-extend to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
    longint m, sx, sy, p;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int exp_lat(input logic [31:0] y, input logic s, input int w);
    longint mag;
    int     l;
    mag = longint'(y) & ((longint'(1) << w) - 1);
    if (s && y[w-1]) mag = (longint'(1) << w) - mag;
    l = 1;
    for (int i = 0; i < w; i++) if (mag[i]) l = i + 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    return l;
`else
    return (l > 0) ? w : w;
`endif
  endfunction

  // One directed operation; hold > 0 stalls the result for that many cycles.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int hold, input string tag);
    int          w;
    int          lat;
    int          guard;
    logic [63:0] r0;
    w     = sel5 ? 5 : 8;
    guard = 0;
    while (!cur_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 64'(cur_in_ready), 64'd1);
    out_ready = (hold == 0);
    a_v       = x;
    b_v       = y;
    is_signed = s;
    in_valid  = 1'b1;
    sb.push_back(ref_mul(x, y, s, w));
    tick();
    in_valid  = 1'b0;
    a_v       = $urandom;
    b_v       = $urandom;
    is_signed = ~s;
    check({tag, "_busy"}, {62'b0, cur_busy, cur_in_ready}, 64'b10);
    lat = 0;
    while (!cur_out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(y, s, w)));
    r0 = cur_result;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      tick();
      check({tag, "_hold"}, {cur_result, 61'b0, cur_out_valid, cur_in_ready, 1'b0} >> 0,
            {r0, 61'b0, 1'b1, 1'b0, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_result"}, cur_result, (sb.size() != 0) ? sb.pop_front() : 64'hx);
    tick();
    check({tag, "_release"}, {62'b0, cur_out_valid, cur_in_ready}, 64'b01);
  endtask

  // Random traffic with random consumer stalls, scoreboard-matched.
  task automatic run_random(input int n, input string tag);
    int   w, issued, got, cyc;
    logic acc;
    w      = sel5 ? 5 : 8;
    issued = 0;
    got    = 0;
    cyc    = 0;
    while (got < n && cyc < 40000) begin
      if (!in_valid && issued < n && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        a_v       = $urandom;
        b_v       = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && cur_in_ready;
      if (acc) begin
        sb.push_back(ref_mul(a_v, b_v, is_signed, w));
        issued++;
      end
      if (cur_out_valid && out_ready) begin
        check({tag, "_result"}, cur_result, (sb.size() != 0) ? sb.pop_front() : 64'hx);
        got++;
      end
      tick();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check({tag, "_got"}, 64'(got), 64'(n));
    check({tag, "_issued"}, 64'(issued), 64'(n));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    is_signed = 1'b0;
    a_v       = '0;
    b_v       = '0;
    sel5      = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state of both instances
    check("rst8", {result8, 13'b0, in_ready8, out_valid8, busy8}, {16'h0, 13'b0, 3'b100});
    check("rst5", {result5, 13'b0, in_ready5, out_valid5, busy5}, {10'h0, 13'b0, 3'b100});

    // Directed WIDTH=8 operations
    run_op(32'd13,  32'd11,  1'b0, 0, "u13x11");
    run_op(32'hFD,  32'h05,  1'b1, 0, "s_m3x5");
    run_op(32'h80,  32'h80,  1'b1, 0, "s_min_sq");
    run_op(32'hFF,  32'hFF,  1'b0, 0, "u_max_sq");
    run_op(32'h5A,  32'h01,  1'b0, 0, "b_one");
    run_op(32'h5A,  32'h00,  1'b0, 0, "b_zero");
    run_op(32'h03,  32'h80,  1'b0, 0, "b_msb");
    run_op(32'h7F,  32'h81,  1'b1, 0, "s_mixed");

    // Backpressure: result held 5 cycles while in_valid pulses are ignored
    run_op(32'd25,  32'd9,   1'b0, 5, "bp");

    // Reset on the third CALC edge discards the operation
    a_v       = 32'hC3;
    b_v       = 32'hFF;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    sb.push_back(ref_mul(a_v, b_v, 1'b0, 8));
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check("midrst", {result8, 13'b0, in_ready8, out_valid8, busy8}, {16'h0, 13'b0, 3'b100});
    run_op(32'd7, 32'd6, 1'b0, 0, "after_rst");

    // Random traffic, WIDTH=8
    run_random(1000, "rnd8");

    // WIDTH=5 instance
    sel5 = 1'b1;
    run_op(32'h10, 32'h10, 1'b1, 0, "w5_min_sq");
    run_op(32'h1F, 32'h1F, 1'b0, 0, "w5_max_sq");
    run_random(1000, "rnd5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_multiplier
